// File: rtl/tl_pkg.sv
// Shared constants for the traffic-light sensor path: lane indices and
// default timing parameters for the sensor conditioner.
package tl_pkg;

    localparam int NUM_LANES = 4;

    localparam int LANE_XL = 0;
    localparam int LANE_XR = 1;
    localparam int LANE_YU = 2;
    localparam int LANE_YD = 3;

    localparam int DEB_CYCLES_DEF   = 4;
    localparam int JAM_HOLD_DEF     = 8;
    localparam int FAULT_CYCLES_DEF = 64;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tl_sensor_debounce.sv
// One-bit sensor conditioning: 2-flop synchroniser followed by a debouncer
// that only moves its level after DEB_CYCLES consecutive differing samples.
module tl_sensor_debounce
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int            CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sample_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] deb_cnt_q;
    logic [CW-1:0] deb_cnt_d;

    // Debounce next state: any agreeing sample restarts the count.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        if (sample_q == level_q) begin
            deb_cnt_d = {CW{1'b0}};
        end else if (deb_cnt_q == CNT_LAST) begin
            level_d   = sample_q;
            deb_cnt_d = {CW{1'b0}};
        end else begin
            deb_cnt_d = deb_cnt_q + CW'(1);
        end
    end

    // Synchroniser flops and debounce state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sample_q  <= 1'b0;
            level_q   <= 1'b0;
            deb_cnt_q <= {CW{1'b0}};
        end else begin
            sync1_q   <= raw;
            sample_q  <= sync1_q;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/tl_sensor_conditioner.sv
// Conditions the eight raw loop-detector inputs for Traffic_light_controller:
// per-bit synchronise + debounce, then per-lane jam qualification that needs
// presence and jam held together for JAM_HOLD cycles.
// Optional feature macro: TL_SENSOR_FAULT_EN adds the sticky per-lane
// sensor_fault output (jam seen without presence for FAULT_CYCLES cycles).
module tl_sensor_conditioner
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int JAM_HOLD     = JAM_HOLD_DEF
`ifdef TL_SENSOR_FAULT_EN
    ,
    parameter int FAULT_CYCLES = FAULT_CYCLES_DEF
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_s1_xL,
    input  logic raw_s1_xR,
    input  logic raw_s1_yU,
    input  logic raw_s1_yD,
    input  logic raw_s2_xL,
    input  logic raw_s2_xR,
    input  logic raw_s2_yU,
    input  logic raw_s2_yD,
    output logic s1_xL,
    output logic s1_xR,
    output logic s1_yU,
    output logic s1_yD,
    output logic s2_xL,
    output logic s2_xR,
    output logic s2_yU,
    output logic s2_yD
`ifdef TL_SENSOR_FAULT_EN
    ,
    output logic [NUM_LANES-1:0] sensor_fault
`endif
);

    localparam int            JW      = cnt_width(JAM_HOLD);
    localparam logic [JW-1:0] JAM_MAX = JW'(JAM_HOLD);
`ifdef TL_SENSOR_FAULT_EN
    localparam int            FW      = cnt_width(FAULT_CYCLES);
    localparam logic [FW-1:0] FLT_MAX = FW'(FAULT_CYCLES);
`endif

    logic [NUM_LANES-1:0] raw1_s;
    logic [NUM_LANES-1:0] raw2_s;
    logic [NUM_LANES-1:0] deb1_s;
    logic [NUM_LANES-1:0] deb2_s;
    logic [NUM_LANES-1:0] jam_s;

    assign raw1_s[LANE_XL] = raw_s1_xL;
    assign raw1_s[LANE_XR] = raw_s1_xR;
    assign raw1_s[LANE_YU] = raw_s1_yU;
    assign raw1_s[LANE_YD] = raw_s1_yD;
    assign raw2_s[LANE_XL] = raw_s2_xL;
    assign raw2_s[LANE_XR] = raw_s2_xR;
    assign raw2_s[LANE_YU] = raw_s2_yU;
    assign raw2_s[LANE_YD] = raw_s2_yD;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [JW-1:0] jam_cnt_q;
        logic [JW-1:0] jam_cnt_d;

        tl_sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_s1 (
            .clk   (clk),
            .reset (reset),
            .raw   (raw1_s[l]),
            .level (deb1_s[l])
        );

        tl_sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_s2 (
            .clk   (clk),
            .reset (reset),
            .raw   (raw2_s[l]),
            .level (deb2_s[l])
        );

        // Jam counter: runs while presence and jam are both up, saturating.
        always_comb begin
            jam_cnt_d = jam_cnt_q;
            if (deb1_s[l] && deb2_s[l]) begin
                if (jam_cnt_q != JAM_MAX) begin
                    jam_cnt_d = jam_cnt_q + JW'(1);
                end else begin
                    jam_cnt_d = jam_cnt_q;
                end
            end else begin
                jam_cnt_d = {JW{1'b0}};
            end
        end

        // Jam counter register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                jam_cnt_q <= {JW{1'b0}};
            end else begin
                jam_cnt_q <= jam_cnt_d;
            end
        end

        // Gating by the live debounced levels makes jam drop on the same
        // edge that either level falls, with no extra hold.
        assign jam_s[l] = (jam_cnt_q == JAM_MAX) & deb1_s[l] & deb2_s[l];

`ifdef TL_SENSOR_FAULT_EN
        logic [FW-1:0] flt_cnt_q;
        logic [FW-1:0] flt_cnt_d;
        logic          flt_q;
        logic          flt_d;

        // Fault counter: jam without presence; the fault bit is sticky.
        always_comb begin
            flt_cnt_d = flt_cnt_q;
            if (deb2_s[l] && !deb1_s[l]) begin
                if (flt_cnt_q != FLT_MAX) begin
                    flt_cnt_d = flt_cnt_q + FW'(1);
                end else begin
                    flt_cnt_d = flt_cnt_q;
                end
            end else begin
                flt_cnt_d = {FW{1'b0}};
            end
            flt_d = flt_q | (flt_cnt_d == FLT_MAX);
        end

        // Fault counter and sticky flag registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                flt_cnt_q <= {FW{1'b0}};
                flt_q     <= 1'b0;
            end else begin
                flt_cnt_q <= flt_cnt_d;
                flt_q     <= flt_d;
            end
        end

        assign sensor_fault[l] = flt_q;
`endif
    end

    assign s1_xL = deb1_s[LANE_XL];
    assign s1_xR = deb1_s[LANE_XR];
    assign s1_yU = deb1_s[LANE_YU];
    assign s1_yD = deb1_s[LANE_YD];
    assign s2_xL = jam_s[LANE_XL];
    assign s2_xR = jam_s[LANE_XR];
    assign s2_yU = jam_s[LANE_YU];
    assign s2_yD = jam_s[LANE_YD];

endmodule
